uart_param_parser: RTL
======================

# uart_param_parser

Parametrised ASCII-decimal parameter entry block. It sits behind `uart_rx`, in the same position as the single-purpose setting subsystems. It accepts 1..`MAX_DIGITS` decimal digits per entry, and an entry ends on CR/LF or on an inter-character timeout. The value is range-checked against `[MIN_VAL, MAX_VAL]`, a one-cycle `param_valid` strobe is raised on acceptance, and `param_error` is held until `enable` drops. Compared with the fixed two-digit, 5–60 version, this block adds configurable width, range and default, terminator support, illegal-character and digit-overflow detection, and clean abort on `enable` loss.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `TIMEOUT_US`, 500, inter-character timeout in µs. `TIMEOUT_CNT = CLK_FREQ/1_000_000*TIMEOUT_US`, which must be ≥ 2.
- `MAX_DIGITS`, 3, maximum digits per entry, legal range 1..6.
- `VALUE_W`, 10, width of `param_value`.
- `MIN_VAL`, 5, inclusive lower bound.
- `MAX_VAL`, 600, inclusive upper bound. Must be < 2^`VALUE_W`.
- `DEFAULT_VAL`, 10, reset value of `param_value`.

Ports:
- `clk`, in, 1, system clock. Rising edge.
- `rst`, in, 1, asynchronous reset, active-high.
- `enable`, in, 1, parser enable (level).
- `uart_rx_done`, in, 1, one-cycle strobe meaning `uart_rx_data` is valid.
- `uart_rx_data`, in, 8, received byte.
- `param_value`, out, `VALUE_W`, last accepted value.
- `param_valid`, out, 1, one-cycle strobe on the cycle `param_value` takes a new value.
- `param_error`, out, 1, rejection flag (level).
- `busy`, out, 1, high in the COLLECT and CHECK states.

## Operation
- **Character classes.**
  - Digit: 0x30–0x39.
  - Terminator: 0x0D or 0x0A.
  - Anything else is illegal.
- **Accumulator.** 20-bit `acc`, updated as `acc <= acc*10 + (byte-0x30)`. A 3-bit digit count `ndig` tracks the number of digits received. 999999 fits in 20 bits, so there is no wrap.
- **States:** IDLE, COLLECT, CHECK, DONE, ERROR. The `err_pend` bit records why CHECK will fail.
- **IDLE.**
  - On `enable && uart_rx_done && digit`: load `acc` with the digit, set `ndig=1`, clear the timer and `err_pend`, go to COLLECT.
  - Terminators and illegal bytes are ignored.
- **COLLECT.** The timer increments every cycle and clears on any `uart_rx_done`.
  - Digit with `ndig<MAX_DIGITS`: accumulate and increment `ndig`.
  - Digit with `ndig==MAX_DIGITS`: set `err_pend` (overflow) and go to CHECK.
  - Terminator: go to CHECK.
  - Illegal byte: set `err_pend` and go to CHECK.
  - Timer reaches `TIMEOUT_CNT-1` with no `uart_rx_done` that cycle: go to CHECK. If `uart_rx_done` and timeout coincide, the byte wins and the timer restarts.
  - `enable` low: abort to IDLE. Outputs are unchanged, with no valid strobe and no error.
- **CHECK** (one cycle).
  - If `!err_pend && MIN_VAL<=acc<=MAX_VAL`: `param_value <= acc[VALUE_W-1:0]`, `param_valid <= 1`, go to DONE.
  - Otherwise: `param_error <= 1`, go to ERROR.
  - `enable` is not sampled in CHECK.
- **DONE / ERROR.**
  - All bytes are ignored.
  - On `enable` low: go to IDLE.
  - `param_error` clears on the cycle the state leaves ERROR.
- **Value retention.** `param_value` changes only through CHECK acceptance. It is otherwise held, including across errors and aborts.

## Timing
- **Reset values:** `param_value=DEFAULT_VAL`, `param_valid=0`, `param_error=0`, `busy=0`. State = IDLE, and `acc`, `ndig`, timer and `err_pend` are all cleared.
- **Reset mid-entry:** `rst` at any point returns the block to the reset values immediately. The partial entry is discarded.
- **Terminator latency.** Terminator strobe sampled at edge E:
  - CHECK during E→E+1.
  - `param_value` updates and `param_valid` is high during E+1→E+2.
  - `busy` falls with `param_valid`.
- **Timeout latency.** Last digit at edge E: CHECK is entered at edge E+`TIMEOUT_CNT`, and the result is visible one edge later.
- **Strobe width.** `param_valid` is exactly one cycle per accepted entry and never asserts alongside `param_error`.
- **Error timing.** `param_error` rises at the same relative edge as `param_valid` would have. It stays high until the first edge after `enable` is sampled low.
- **Back-to-back entries.** A new entry requires a pass through IDLE, so `enable` must be deasserted between entries.

## Test plan
Bench settings: `CLK_FREQ=1_000_000`, `TIMEOUT_US=50` (`TIMEOUT_CNT=50`), defaults otherwise.

- Reset, then idle → `param_value=10`, all flags 0.
- enable=1, send "4","2",CR → `param_valid` pulses 2 cycles after the CR strobe, `param_value=42`, `param_error=0`.
- Send "7", wait 49 cycles, then "5", then "0", then idle → timer restarts on each byte, `param_value=750`? No: 750>600, so `param_error` rises and stays high until enable=0, after which it clears the next cycle. Then re-enable and send "6","0","0",LF → `param_value=600`.
- Send "1","2","3","4" → overflow: `param_error=1`, `param_value` unchanged. Send "3",CR → `param_error=1` (3<5). Send "1","x" → `param_error=1`.
- Send "5","5", drop enable at cycle 10 → no `param_valid`, no error, `param_value` unchanged. Re-enable and send "9",CR → `param_value=9`.
- Assert `rst` in the middle of "2","5" → all outputs return to reset values. Then timeout and coincident-byte case: a byte on cycle 49 of the timer → entry continues and the resulting value includes that byte.

Source files
------------

// File: rtl/uart_param_parser.sv
// uart_param_parser: ASCII-decimal parameter entry behind a UART receiver.
// It collects 1..MAX_DIGITS digits that end on CR/LF or on an inter-character
// timeout, range-checks the value and either publishes it with a one-cycle
// strobe or raises an error flag that is held until enable drops.
module uart_param_parser #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TIMEOUT_US  = 500,
  parameter int MAX_DIGITS  = 3,
  parameter int VALUE_W     = 10,
  parameter int MIN_VAL     = 5,
  parameter int MAX_VAL     = 600,
  parameter int DEFAULT_VAL = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               uart_rx_done,
  input  logic [7:0]         uart_rx_data,
  output logic [VALUE_W-1:0] param_value,
  output logic               param_valid,
  output logic               param_error,
  output logic               busy
);

  localparam int TIMEOUT_CNT = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int TIMER_W     = $clog2(TIMEOUT_CNT) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CNT - 1);
  localparam logic [2:0]         NDIG_MAX   = 3'(MAX_DIGITS);

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DONE, ERROR} state_t;

  state_t               state_reg, state_next;
  logic [19:0]          acc_reg, acc_next;
  logic [2:0]           ndig_reg, ndig_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic                 err_pend_reg, err_pend_next;
  logic [VALUE_W-1:0]   value_reg, value_next;
  logic                 valid_reg, valid_next;
  logic                 error_reg, error_next;

  // Byte classification; a digit's value is simply its low nibble.
  logic        is_digit;
  logic        is_term;
  logic [19:0] digit_val;
  logic        in_range;

  assign is_digit  = (uart_rx_data >= 8'h30) && (uart_rx_data <= 8'h39);
  assign is_term   = (uart_rx_data == 8'h0D) || (uart_rx_data == 8'h0A);
  assign digit_val = {16'd0, uart_rx_data[3:0]};
  assign in_range  = (acc_reg >= 20'(MIN_VAL)) && (acc_reg <= 20'(MAX_VAL));

  // State and datapath registers; reset discards any partial entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      ndig_reg     <= '0;
      timer_reg    <= '0;
      err_pend_reg <= 1'b0;
      value_reg    <= VALUE_W'(DEFAULT_VAL);
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      ndig_reg     <= ndig_next;
      timer_reg    <= timer_next;
      err_pend_reg <= err_pend_next;
      value_reg    <= value_next;
      valid_reg    <= valid_next;
      error_reg    <= error_next;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    ndig_next     = ndig_reg;
    timer_next    = timer_reg;
    err_pend_next = err_pend_reg;
    value_next    = value_reg;
    valid_next    = 1'b0;
    error_next    = error_reg;

    case (state_reg)
      IDLE: begin
        // Only a digit opens an entry; stray terminators/junk are dropped.
        if (enable && uart_rx_done && is_digit) begin
          acc_next      = digit_val;
          ndig_next     = 3'd1;
          timer_next    = '0;
          err_pend_next = 1'b0;
          state_next    = COLLECT;
        end
      end
      COLLECT: begin
        if (!enable) begin
          // Silent abort: outputs untouched.
          state_next = IDLE;
        end else if (uart_rx_done) begin
          // A byte always beats a coinciding timeout and restarts the timer.
          timer_next = '0;
          if (is_digit) begin
            if (ndig_reg < NDIG_MAX) begin
              acc_next  = acc_reg * 20'd10 + digit_val;
              ndig_next = ndig_reg + 3'd1;
            end else begin
              err_pend_next = 1'b1;
              state_next    = CHECK;
            end
          end else if (is_term) begin
            state_next = CHECK;
          end else begin
            err_pend_next = 1'b1;
            state_next    = CHECK;
          end
        end else if (timer_reg == TIMER_LAST) begin
          state_next = CHECK;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      CHECK: begin
        if (!err_pend_reg && in_range) begin
          value_next = acc_reg[VALUE_W-1:0];
          valid_next = 1'b1;
          state_next = DONE;
        end else begin
          error_next = 1'b1;
          state_next = ERROR;
        end
      end
      DONE: begin
        if (!enable) state_next = IDLE;
      end
      ERROR: begin
        if (!enable) begin
          error_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign param_value = value_reg;
  assign param_valid = valid_reg;
  assign param_error = error_reg;
  assign busy        = (state_reg == COLLECT) || (state_reg == CHECK);

endmodule
